// File: rtl/step_pkg.sv
// Shared defaults and the lane result payload for the step accumulator.
package step_pkg;

    localparam int unsigned DEF_STEPS       = 3;
    localparam int unsigned DEF_WORD_WIDTH  = 16;
    localparam int unsigned DEF_ACC_WIDTH   = 32;
    localparam int unsigned DEF_TUSER_WIDTH = 4;

    typedef struct packed {
        logic                       valid;
        logic [DEF_ACC_WIDTH-1:0]   data;
        logic                       last;
        logic [DEF_TUSER_WIDTH-1:0] user;
    } lane_res_t;

endpackage

// File: rtl/step_accumulator_lane.sv
// Single-lane accumulator: first-beat base load, running sum, registered result pulse.
module acc_lane
    import step_pkg::*;
#(
    parameter int unsigned WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int unsigned TUSER_WIDTH = DEF_TUSER_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en_i,
    input  logic                   emit_i,
    input  logic                   in_valid_i,
    input  logic [WORD_WIDTH-1:0]  in_data_i,
    input  logic                   in_last_i,
    input  logic [TUSER_WIDTH-1:0] in_user_i,
    input  logic [ACC_WIDTH-1:0]   base_i,
    output logic                   first_o,
    output logic                   done_c,
    output logic [ACC_WIDTH-1:0]   sum_c,
    output logic                   res_valid_o,
    output logic [ACC_WIDTH-1:0]   res_data_o,
    output logic [TUSER_WIDTH-1:0] res_user_o
);

    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic                   first_q, first_d;
    logic                   res_valid_q, res_valid_d;
    logic [ACC_WIDTH-1:0]   res_data_q, res_data_d;
    logic [TUSER_WIDTH-1:0] res_user_q, res_user_d;

    // Sum is exposed combinationally so the next lane can bypass it.
    always_comb begin
        acc_d       = acc_q;
        first_d     = first_q;
        res_valid_d = 1'b0;
        res_data_d  = '0;
        res_user_d  = '0;
        sum_c       = (first_q ? base_i : acc_q) + ACC_WIDTH'($signed(in_data_i));
        done_c      = in_valid_i & in_last_i;
        if (in_valid_i) begin
            acc_d   = sum_c;
            first_d = in_last_i;
        end
        if (done_c && emit_i) begin
            res_valid_d = 1'b1;
            res_data_d  = sum_c;
            res_user_d  = in_user_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            first_q     <= 1'b1;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_user_q  <= '0;
        end else if (en_i) begin
            acc_q       <= acc_d;
            first_q     <= first_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_user_q  <= res_user_d;
        end
    end

    assign first_o     = first_q;
    assign res_valid_o = res_valid_q;
    assign res_data_o  = res_data_q;
    assign res_user_o  = res_user_q;

endmodule

// File: rtl/step_accumulator.sv
// Staggered multi-lane accumulator; in nxm mode each lane's sum seeds the next lane.
module step_accumulator
    import step_pkg::*;
#(
    parameter int unsigned STEPS       = DEF_STEPS,
    parameter int unsigned WORD_WIDTH  = DEF_WORD_WIDTH,
    parameter int unsigned ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int unsigned TUSER_WIDTH = DEF_TUSER_WIDTH
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                aclken,
    input  logic                                is_1x1,
    input  logic [STEPS-1:0]                    s_valid,
    input  logic [STEPS-1:0][WORD_WIDTH-1:0]    s_data,
    input  logic [STEPS-1:0]                    s_last,
    input  logic [STEPS-1:0][TUSER_WIDTH-1:0]   s_user,
    output logic [STEPS-1:0]                    m_valid,
    output logic [STEPS-1:0][ACC_WIDTH-1:0]     m_data,
    output logic [STEPS-1:0]                    m_last,
    output logic [STEPS-1:0][TUSER_WIDTH-1:0]   m_user,
    output logic                                err_overrun,
    output logic                                err_underrun
);

    logic [STEPS-1:0]                lane_first;
    logic [STEPS-1:0]                lane_done;
    logic [STEPS-1:0]                lane_start;
    logic [STEPS-1:0][ACC_WIDTH-1:0] lane_sum;
    logic [STEPS-1:0][ACC_WIDTH-1:0] lane_base;

    logic [STEPS-1:1]                pend_q, pend_d;
    logic [STEPS-1:1][ACC_WIDTH-1:0] chain_q, chain_d;
    logic                            ovr_q, ovr_d;
    logic                            und_q, und_d;

    assign lane_start = s_valid & lane_first;

    // Chain source priority: same-cycle bypass, then held value, else underrun.
    always_comb begin
        pend_d    = pend_q;
        chain_d   = chain_q;
        ovr_d     = ovr_q;
        und_d     = und_q;
        lane_base = '0;
        for (int unsigned i = 1; i < STEPS; i++) begin
            if (!is_1x1) begin
                if (lane_done[i-1] && lane_start[i]) begin
                    lane_base[i] = lane_sum[i-1];
                end else if (pend_q[i]) begin
                    lane_base[i] = chain_q[i];
                    if (lane_start[i]) begin
                        pend_d[i] = 1'b0;
                    end
                end else if (lane_start[i]) begin
                    und_d = 1'b1;
                end
                if (lane_done[i-1] && !lane_start[i]) begin
                    if (pend_q[i]) begin
                        ovr_d = 1'b1;
                    end
                    chain_d[i] = lane_sum[i-1];
                    pend_d[i]  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pend_q  <= '0;
            chain_q <= '0;
            ovr_q   <= 1'b0;
            und_q   <= 1'b0;
        end else if (aclken) begin
            pend_q  <= pend_d;
            chain_q <= chain_d;
            ovr_q   <= ovr_d;
            und_q   <= und_d;
        end
    end

    for (genvar g = 0; g < STEPS; g++) begin : g_lane
        acc_lane #(
            .WORD_WIDTH  (WORD_WIDTH),
            .ACC_WIDTH   (ACC_WIDTH),
            .TUSER_WIDTH (TUSER_WIDTH)
        ) u_lane (
            .clk         (aclk),
            .rst_n       (aresetn),
            .en_i        (aclken),
            .emit_i      (is_1x1 || (g == STEPS - 1)),
            .in_valid_i  (s_valid[g]),
            .in_data_i   (s_data[g]),
            .in_last_i   (s_last[g]),
            .in_user_i   (s_user[g]),
            .base_i      (lane_base[g]),
            .first_o     (lane_first[g]),
            .done_c      (lane_done[g]),
            .sum_c       (lane_sum[g]),
            .res_valid_o (m_valid[g]),
            .res_data_o  (m_data[g]),
            .res_user_o  (m_user[g])
        );
    end

    assign m_last       = m_valid;
    assign err_overrun  = ovr_q;
    assign err_underrun = und_q;

endmodule
